// File: rtl/program_loader_if.sv
// Byte-stream input and processor program-load bus of the program loader.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int WORD_WIDTH = 37
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  cpu_wr;
  logic [ADDR_WIDTH-1:0] cpu_address;
  logic [WORD_WIDTH-1:0] cpu_data_in;
  logic                  cpu_reset;

  modport slave  (input in_valid, in_data,
                  output in_ready, cpu_wr, cpu_address, cpu_data_in, cpu_reset);
  modport master (output in_valid, in_data,
                  input in_ready, cpu_wr, cpu_address, cpu_data_in, cpu_reset);
endinterface

// File: rtl/program_loader.sv
// Loads a byte stream (count header + 5-byte words) into processor memory, holding it in reset meanwhile.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int ADDR_WIDTH     = 7,
  parameter int WORD_WIDTH     = 37,
  parameter int MAX_WORDS      = 81,
  parameter int BYTES_PER_WORD = 5
)(
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  program_loader_if.slave bus,
  output logic busy,
  output logic done,
  output logic error
);
  localparam logic [7:0] MAX_N  = 8'(MAX_WORDS);
  localparam logic [2:0] LAST_B = 3'(BYTES_PER_WORD - 1);
  localparam int         ASM_W  = WORD_WIDTH - 8;

  typedef enum logic [2:0] {IDLE, HEADER, BYTES, WRITE, CHECK, RELEASE, ERROR} state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] idx, idx_n;
  logic [7:0]            nwords, nwords_n;
  logic [2:0]            bcnt, bcnt_n;
  logic [ASM_W-1:0]      asm_q, asm_n;
  logic [WORD_WIDTH-1:0] word;
  logic                  rdy_q, rdy_n, wr_q, wr_n, crst_q, crst_n;
  logic                  busy_q, busy_n, done_q, done_n, err_q, err_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [WORD_WIDTH-1:0] data_q, data_n;
  logic                  xfer;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum, csum_n;
`endif

  assign xfer = bus.in_valid & rdy_q;
  // Register keeps only the low bits of the previous bytes, so the top 3 bits of a 40-bit word fall off.
  assign word = {asm_q, bus.in_data};

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    nwords_n = nwords;
    bcnt_n   = bcnt;
    asm_n    = asm_q;
    wr_n     = 1'b0;
    addr_n   = addr_q;
    data_n   = data_q;
    crst_n   = crst_q;
    busy_n   = busy_q;
    done_n   = done_q;
    err_n    = err_q;
`ifdef LOADER_CHECKSUM_EN
    csum_n   = csum;
    if (xfer) csum_n = csum ^ bus.in_data;
`endif
    unique case (state)
      IDLE: if (start) begin
        state_n = HEADER;
        crst_n  = 1'b1;
        busy_n  = 1'b1;
        done_n  = 1'b0;
        err_n   = 1'b0;
        idx_n   = '0;
        bcnt_n  = '0;
`ifdef LOADER_CHECKSUM_EN
        csum_n  = '0;
`endif
      end
      HEADER: if (xfer) begin
        if (bus.in_data == 8'd0 || bus.in_data > MAX_N) begin
          state_n = ERROR;
          busy_n  = 1'b0;
          err_n   = 1'b1;
        end else begin
          state_n  = BYTES;
          nwords_n = bus.in_data;
        end
      end
      BYTES: if (xfer) begin
        asm_n  = word[ASM_W-1:0];
        bcnt_n = bcnt + 3'd1;
        if (bcnt == LAST_B) begin
          state_n = WRITE;
          bcnt_n  = '0;
          wr_n    = 1'b1;
          crst_n  = 1'b0;
          addr_n  = idx;
          data_n  = word;
        end
      end
      WRITE: begin
        crst_n = 1'b1;
        idx_n  = idx + ADDR_WIDTH'(1);
        if (8'(idx) + 8'd1 == nwords)
`ifdef LOADER_CHECKSUM_EN
          state_n = CHECK;
`else
          state_n = RELEASE;
`endif
        else
          state_n = BYTES;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: if (xfer) begin
        if (bus.in_data == csum) state_n = RELEASE;
        else begin
          state_n = ERROR;
          busy_n  = 1'b0;
          err_n   = 1'b1;
        end
      end
`endif
      RELEASE: begin
        state_n = IDLE;
        crst_n  = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b1;
      end
      ERROR:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
    rdy_n = (state_n == HEADER) || (state_n == BYTES) || (state_n == CHECK);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      idx    <= '0;
      nwords <= '0;
      bcnt   <= '0;
      asm_q  <= '0;
      rdy_q  <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      crst_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum   <= '0;
`endif
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      nwords <= nwords_n;
      bcnt   <= bcnt_n;
      asm_q  <= asm_n;
      rdy_q  <= rdy_n;
      wr_q   <= wr_n;
      addr_q <= addr_n;
      data_q <= data_n;
      crst_q <= crst_n;
      busy_q <= busy_n;
      done_q <= done_n;
      err_q  <= err_n;
`ifdef LOADER_CHECKSUM_EN
      csum   <= csum_n;
`endif
    end
  end

  assign bus.in_ready    = rdy_q;
  assign bus.cpu_wr      = wr_q;
  assign bus.cpu_address = addr_q;
  assign bus.cpu_data_in = data_q;
  assign bus.cpu_reset   = crst_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = err_q;
endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader; checksum scenarios run when LOADER_CHECKSUM_EN is defined.
module tb_program_loader;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, error;

  program_loader_if #(.ADDR_WIDTH(7), .WORD_WIDTH(37)) bus();

  program_loader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .bus(bus),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wcount = 0;
  logic [43:0] exp_q[$];
  logic [39:0] raw_q[$];
  logic [36:0] expw_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse is matched against the next expected {address, word}.
  initial forever begin
    @(negedge clk);
    if (bus.cpu_wr === 1'b1) begin
      wcount++;
      chk("wr_window", {62'd0, bus.cpu_reset, bus.in_ready}, 64'd0);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0h", bus.cpu_address, bus.cpu_data_in);
      end else begin
        logic [43:0] e;
        e = exp_q.pop_front();
        if ({bus.cpu_address, bus.cpu_data_in} !== e) begin
          errors++;
          $display("FAIL write: got addr %0d data %0h expected addr %0d data %0h",
                   bus.cpu_address, bus.cpu_data_in, e[43:37], e[36:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int c;
    c = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy !== 1'b0 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("busy_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic load(input int n_hdr, input bit gap, input bit bad_cs, input bit start_mid);
    logic [7:0] cs, b;
    int w0;
    bit hdr_ok, ok;
    hdr_ok = (n_hdr >= 1) && (n_hdr <= 81);
    ok = hdr_ok && !bad_cs;
    w0 = wcount;
    cs = 8'(n_hdr);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("start_busy", {63'd0, busy}, 64'd1);
    chk("start_cpu_reset", {63'd0, bus.cpu_reset}, 64'd1);
    send_byte(8'(n_hdr), gap);
    if (hdr_ok) begin
      for (int i = 0; i < raw_q.size(); i++) begin
        exp_q.push_back({7'(i), expw_q[i]});
        for (int k = 0; k < 5; k++) begin
          b = raw_q[i][39-8*k -: 8];
          cs = cs ^ b;
          send_byte(b, gap);
        end
        if (start_mid && i == 0) begin
          start = 1'b1;
          @(negedge clk) start = 1'b0;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(bad_cs ? (cs ^ 8'h07) : cs, gap);
`endif
    end
    wait_idle();
    chk("done", {63'd0, done}, {63'd0, ok});
    chk("error", {63'd0, error}, {63'd0, !ok});
    chk("cpu_reset_end", {63'd0, bus.cpu_reset}, {63'd0, !ok});
    chk("write_count", 64'(wcount - w0), hdr_ok ? 64'(n_hdr) : 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, {63'd0, bus.in_ready}, 64'd0);
    chk({tag, "_cpu_wr"}, {63'd0, bus.cpu_wr}, 64'd0);
    chk({tag, "_cpu_address"}, 64'(bus.cpu_address), 64'd0);
    chk({tag, "_cpu_data_in"}, 64'(bus.cpu_data_in), 64'd0);
    chk({tag, "_cpu_reset"}, {63'd0, bus.cpu_reset}, 64'd1);
    chk({tag, "_flags"}, {61'd0, busy, done, error}, 64'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #12;
    chk_reset_state("reset");
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);

    // Single MOVI 42.
    raw_q = {40'h10_0000_002A};
    expw_q = {37'h10_0000_002A};
    load(1, 1'b0, 1'b0, 1'b0);

    // Three words, valid toggling, discarded top bits, stray start mid-session.
    raw_q = {40'h00_0000_0001, 40'hF3_1234_5678, 40'h1F_FFFF_FFFF};
    expw_q = {37'h00_0000_0001, 37'h13_1234_5678, 37'h1F_FFFF_FFFF};
    load(3, 1'b1, 1'b0, 1'b1);

    // Illegal headers.
    raw_q.delete(); expw_q.delete();
    load(0, 1'b0, 1'b0, 1'b0);
    load(82, 1'b0, 1'b0, 1'b0);

    // Full memory: last write at address 80.
    raw_q.delete(); expw_q.delete();
    for (int i = 0; i < 81; i++) begin
      raw_q.push_back({8'(i), 32'(i) * 32'h0101_0101});
      expw_q.push_back({5'(i), 32'(i) * 32'h0101_0101});
    end
    load(81, 1'b0, 1'b0, 1'b0);

    // Reset after the 3rd byte of word 1.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    send_byte(8'd2, 1'b0);
    exp_q.push_back({7'd0, 37'h0A_0B0C_0D0E});
    send_byte(8'h0A, 1'b0); send_byte(8'h0B, 1'b0); send_byte(8'h0C, 1'b0);
    send_byte(8'h0D, 1'b0); send_byte(8'h0E, 1'b0);
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0);
    chk("pre_reset_busy", {63'd0, busy}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk_reset_state("midreset");
    exp_q.delete();
    @(negedge clk) reset_n = 1'b1;
    raw_q = {40'h02_0000_0005};
    expw_q = {37'h02_0000_0005};
    load(1, 1'b0, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    raw_q = {40'h10_0000_002A};
    expw_q = {37'h10_0000_002A};
    load(1, 1'b0, 1'b1, 1'b0);
    load(1, 1'b1, 1'b0, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
